stream_mem_loader: RTL and testbench
====================================

Name: stream_mem_loader

Overview:
- Host-side writer for the accelerator's on-chip memories; the counterpart to the controller, which only reads them.
- Pops 32-bit words from the host input FIFO (first-word-fall-through) and parses packets of the form header + payload.
- Writes each payload into instruction memory, one neural unit's weight memory, or XY memory.
- Also issues a one-cycle controller start pulse when commanded.

Parameters:
- DATA_WIDTH, 32, FIFO word and memory write-data width
- NU_COUNT, 4, number of neural units (weight memories)
- INST_MEM_DEPTH, 8, instruction memory address bits
- W_MEM_DEPTH, 8, weight memory address bits
- XY_MEM_DEPTH, 8, XY memory address bits

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- buffer_empty  in  1  FIFO has no word
- buffer_data  in  DATA_WIDTH  FIFO head word, valid while buffer_empty=0
- buffer_read_enable  out  1  pop head word this cycle
- controller_active  in  1  controller is executing; blocks instruction loads
- controller_start  out  1  one-cycle start pulse
- inst_write_enable  out  1  instruction memory write strobe
- inst_write_addr  out  INST_MEM_DEPTH  instruction memory write address
- w_write_enable  out  NU_COUNT  one-hot weight memory write strobe
- w_write_addr  out  W_MEM_DEPTH  weight memory write address
- xy_write_enable  out  1  XY memory write strobe
- xy_write_addr  out  XY_MEM_DEPTH  XY memory write address
- write_data  out  DATA_WIDTH  shared write data for all memories
- busy  out  1  high while not in HEADER state or while a write is pending
- error  out  1  sticky; cleared only by reset

Behaviour:
- Header fields:
  - [31:30] target: 00 INST, 01 W, 10 XY, 11 CTRL
  - [29:24] nu_sel (W target only)
  - [23:12] length, unsigned, number of payload words
  - [11:0] base address
- States: HEADER, PAYLOAD, DRAIN.
- buffer_read_enable = ~buffer_empty & (state PAYLOAD or DRAIN, or HEADER with header not stalled). It is never asserted while buffer_empty=1.
- Stall rule: in HEADER, if the head word has target INST and controller_active=1, do not pop; stay in HEADER. The pop occurs in the first cycle controller_active=0.
- Header pop, CTRL target: controller_start=1 in the next cycle for exactly one cycle; length is ignored; stay in HEADER.
- Header pop, length=0: no writes; stay in HEADER.
- Header pop, illegal header (nu_sel >= NU_COUNT for W, or base+length > 2^DEPTH of the target memory, computed at 13 bits with no wrap):
  - error<=1
  - go to DRAIN with remaining count = length
- Header pop, legal header: latch target, nu_sel, base and remaining count = length; go to PAYLOAD.
- PAYLOAD:
  - Each pop registers write_data=buffer_data and addr=base+index, truncated to the target's DEPTH.
  - The matching write_enable pulses in the next cycle (one-cycle latency).
  - Remaining count decrements on each pop. The pop of the last word returns to HEADER in the same edge.
  - An empty FIFO inserts bubbles: no enable, address not advanced.
- DRAIN: pop and discard length words, no write strobes; then go to HEADER.
- Back-to-back packets: a header may be popped in the cycle after the last payload pop. The pending write for the last payload word still issues in that cycle.
- Unselected write enables are 0 and addresses hold their last value. Only one enable bit across all memories is high in any cycle.
- Reset (asynchronous, any time, including mid-packet):
  - state=HEADER
  - all enables, controller_start, buffer_read_enable, busy, error = 0
  - addresses and write_data = 0
  - remaining count = 0
  - partial packet abandoned; no recovery of its payload

Test Plan:
- INST load: header 0x00003010 (INST, len 3, base 0x10), payload A,B,C, FIFO never empty → inst_write_enable high for 3 consecutive cycles starting 2 cycles after header pop; addrs 0x10,0x11,0x12; data A,B,C; busy falls afterwards.
- W load to NU 2: header 0x42002005 (W, nu 2, len 2, base 5) with buffer_empty=1 for 2 cycles between payload words → w_write_enable=4'b0100 twice, addrs 5,6, with a 2-cycle gap; no other enable ever high.
- Interlock: INST header at FIFO head with controller_active=1 for 10 cycles → buffer_read_enable=0 for those 10 cycles; pop in the cycle controller_active drops; writes then proceed normally.
- Illegal packets:
  - header W nu_sel=7 len 4 + 4 payload words → error=1, 4 words popped, zero write strobes; next legal XY packet writes correctly.
  - header INST base 0xFE len 3 → error, drained.
- CTRL then back-to-back: header 0xC0000000 → controller_start high exactly 1 cycle; then XY len 1 base 0 immediately followed by XY len 1 base 1 → two xy writes on consecutive write cycles, no lost word.
- Reset mid-PAYLOAD: assert reset low after 1 of 3 payload words → all outputs 0 immediately (asynchronously); after release, the next word is parsed as a header.

Source files
------------

// File: rtl/stream_mem_loader_if.sv
// rtl/stream_mem_loader_if.sv - host FIFO, controller and memory write signals of the memory loader
interface stream_mem_loader_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int NU_COUNT       = 4,
    parameter int INST_MEM_DEPTH = 8,
    parameter int W_MEM_DEPTH    = 8,
    parameter int XY_MEM_DEPTH   = 8
);
    logic                      buffer_empty;
    logic [DATA_WIDTH-1:0]     buffer_data;
    logic                      buffer_read_enable;
    logic                      controller_active;
    logic                      controller_start;
    logic                      inst_write_enable;
    logic [INST_MEM_DEPTH-1:0] inst_write_addr;
    logic [NU_COUNT-1:0]       w_write_enable;
    logic [W_MEM_DEPTH-1:0]    w_write_addr;
    logic                      xy_write_enable;
    logic [XY_MEM_DEPTH-1:0]   xy_write_addr;
    logic [DATA_WIDTH-1:0]     write_data;
    logic                      busy;
    logic                      error;

    modport master (
        input  buffer_empty, buffer_data, controller_active,
        output buffer_read_enable, controller_start,
               inst_write_enable, inst_write_addr,
               w_write_enable, w_write_addr,
               xy_write_enable, xy_write_addr,
               write_data, busy, error
    );

    modport slave (
        output buffer_empty, buffer_data, controller_active,
        input  buffer_read_enable, controller_start,
               inst_write_enable, inst_write_addr,
               w_write_enable, w_write_addr,
               xy_write_enable, xy_write_addr,
               write_data, busy, error
    );
endinterface

// File: rtl/stream_mem_loader.sv
// rtl/stream_mem_loader.sv - parses header+payload packets from the host FIFO into the accelerator memories
module stream_mem_loader #(
    parameter int DATA_WIDTH     = 32,
    parameter int NU_COUNT       = 4,
    parameter int INST_MEM_DEPTH = 8,
    parameter int W_MEM_DEPTH    = 8,
    parameter int XY_MEM_DEPTH   = 8
) (
    input  logic                clk,
    input  logic                reset,
    stream_mem_loader_if.master bus
);

    typedef enum logic [1:0] {HEADER, PAYLOAD, DRAIN} state_t;

    localparam logic [1:0] T_INST = 2'b00;
    localparam logic [1:0] T_W    = 2'b01;
    localparam logic [1:0] T_XY   = 2'b10;
    localparam logic [1:0] T_CTRL = 2'b11;

    localparam int NU_W = (NU_COUNT > 1) ? $clog2(NU_COUNT) : 1;

    // Memory sizes at 13 bits so base+length can be checked without wrapping
    localparam logic [12:0] INST_LIMIT = 13'(1) << INST_MEM_DEPTH;
    localparam logic [12:0] W_LIMIT    = 13'(1) << W_MEM_DEPTH;
    localparam logic [12:0] XY_LIMIT   = 13'(1) << XY_MEM_DEPTH;
    localparam logic [6:0]  NU_LIMIT   = 7'(NU_COUNT);

    state_t                    state_q, state_d;
    logic [1:0]                target_q, target_d;
    logic [NU_W-1:0]           nu_q, nu_d;
    logic [11:0]               ptr_q, ptr_d;
    logic [11:0]               rem_q, rem_d;
    logic                      inst_we_q, inst_we_d;
    logic [NU_COUNT-1:0]       w_we_q, w_we_d;
    logic                      xy_we_q, xy_we_d;
    logic [INST_MEM_DEPTH-1:0] inst_addr_q, inst_addr_d;
    logic [W_MEM_DEPTH-1:0]    w_addr_q, w_addr_d;
    logic [XY_MEM_DEPTH-1:0]   xy_addr_q, xy_addr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic                      start_q, start_d;
    logic                      error_q, error_d;

    logic [1:0]  hdr_target;
    logic [5:0]  hdr_nu;
    logic [11:0] hdr_len;
    logic [11:0] hdr_base;
    logic [12:0] hdr_end;
    logic [12:0] hdr_limit;
    logic        hdr_illegal;
    logic        hdr_stall;
    logic        pop;

    // The head word is only meaningful as a header while in HEADER
    assign hdr_target = bus.buffer_data[31:30];
    assign hdr_nu     = bus.buffer_data[29:24];
    assign hdr_len    = bus.buffer_data[23:12];
    assign hdr_base   = bus.buffer_data[11:0];
    assign hdr_end    = {1'b0, hdr_base} + {1'b0, hdr_len};

    // Size of the memory the header targets
    always_comb begin
        hdr_limit = INST_LIMIT;
        case (hdr_target)
            T_W:     hdr_limit = W_LIMIT;
            T_XY:    hdr_limit = XY_LIMIT;
            default: hdr_limit = INST_LIMIT;
        endcase
    end

    assign hdr_illegal = ((hdr_target == T_W) && ({1'b0, hdr_nu} >= NU_LIMIT)) ||
                         (hdr_end > hdr_limit);

    // Instruction memory may not be rewritten under a running controller
    assign hdr_stall = (hdr_target == T_INST) && bus.controller_active;

    // Gated by reset so no word is consumed while the block is held in reset
    assign pop = reset && !bus.buffer_empty && ((state_q != HEADER) || !hdr_stall);

    assign bus.buffer_read_enable = pop;
    assign bus.controller_start   = start_q;
    assign bus.inst_write_enable  = inst_we_q;
    assign bus.inst_write_addr    = inst_addr_q;
    assign bus.w_write_enable     = w_we_q;
    assign bus.w_write_addr       = w_addr_q;
    assign bus.xy_write_enable    = xy_we_q;
    assign bus.xy_write_addr      = xy_addr_q;
    assign bus.write_data         = wdata_q;
    assign bus.error              = error_q;
    assign bus.busy               = (state_q != HEADER) || inst_we_q || (|w_we_q) || xy_we_q;

    // Packet parser: header decode, payload write scheduling and drain of rejected packets
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        nu_d        = nu_q;
        ptr_d       = ptr_q;
        rem_d       = rem_q;
        inst_we_d   = 1'b0;
        w_we_d      = '0;
        xy_we_d     = 1'b0;
        inst_addr_d = inst_addr_q;
        w_addr_d    = w_addr_q;
        xy_addr_d   = xy_addr_q;
        wdata_d     = wdata_q;
        start_d     = 1'b0;
        error_d     = error_q;

        case (state_q)
            HEADER: begin
                if (pop) begin
                    if (hdr_target == T_CTRL) begin
                        start_d = 1'b1;
                    end else if (hdr_len != 12'd0) begin
                        if (hdr_illegal) begin
                            error_d = 1'b1;
                            rem_d   = hdr_len;
                            state_d = DRAIN;
                        end else begin
                            target_d = hdr_target;
                            nu_d     = hdr_nu[NU_W-1:0];
                            ptr_d    = hdr_base;
                            rem_d    = hdr_len;
                            state_d  = PAYLOAD;
                        end
                    end
                end
            end
            PAYLOAD: begin
                if (pop) begin
                    wdata_d = bus.buffer_data;
                    case (target_q)
                        T_INST: begin
                            inst_we_d   = 1'b1;
                            inst_addr_d = ptr_q[INST_MEM_DEPTH-1:0];
                        end
                        T_W: begin
                            w_we_d   = NU_COUNT'(1) << nu_q;
                            w_addr_d = ptr_q[W_MEM_DEPTH-1:0];
                        end
                        default: begin
                            xy_we_d   = 1'b1;
                            xy_addr_d = ptr_q[XY_MEM_DEPTH-1:0];
                        end
                    endcase
                    ptr_d = ptr_q + 12'd1;
                    rem_d = rem_q - 12'd1;
                    if (rem_q == 12'd1) begin
                        state_d = HEADER;
                    end
                end
            end
            DRAIN: begin
                if (pop) begin
                    rem_d = rem_q - 12'd1;
                    if (rem_q == 12'd1) begin
                        state_d = HEADER;
                    end
                end
            end
            default: state_d = HEADER;
        endcase
    end

    // State and registered outputs; reset abandons any partial packet
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= HEADER;
            target_q    <= T_INST;
            nu_q        <= '0;
            ptr_q       <= '0;
            rem_q       <= '0;
            inst_we_q   <= 1'b0;
            w_we_q      <= '0;
            xy_we_q     <= 1'b0;
            inst_addr_q <= '0;
            w_addr_q    <= '0;
            xy_addr_q   <= '0;
            wdata_q     <= '0;
            start_q     <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            nu_q        <= nu_d;
            ptr_q       <= ptr_d;
            rem_q       <= rem_d;
            inst_we_q   <= inst_we_d;
            w_we_q      <= w_we_d;
            xy_we_q     <= xy_we_d;
            inst_addr_q <= inst_addr_d;
            w_addr_q    <= w_addr_d;
            xy_addr_q   <= xy_addr_d;
            wdata_q     <= wdata_d;
            start_q     <= start_d;
            error_q     <= error_d;
        end
    end

endmodule

// File: tb/tb_stream_mem_loader.sv
// tb/tb_stream_mem_loader.sv - self-checking bench for stream_mem_loader
module tb_stream_mem_loader;

    typedef struct packed {
        logic [1:0]  mem;
        logic [1:0]  nu;
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    stream_mem_loader_if bus ();

    stream_mem_loader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] fifo[$];
    wr_t         exp_q[$];
    int          pop_cycles[$];
    int          write_cycles[$];
    int          n_assert = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          pops = 0;
    int          start_seen = 0;
    int          exp_starts = 0;
    int          hold = 0;
    int          gap_len = 0;
    bit          rand_gap = 0;
    bit          rand_ca = 0;
    bit          ca_next = 0;
    bit          pop_flag = 0;
    bit          exp_error = 0;

    task automatic check(input string tag, input bit ok);
        n_assert++;
        if (!ok) begin
            n_fail++;
            $error("FAIL %s", tag);
        end
    endtask

    task automatic cycle();
        int  n_en;
        bit  have_exp;
        wr_t obs;
        wr_t e;
        @(negedge clk);
        if (pop_flag && fifo.size() != 0) begin
            void'(fifo.pop_front());
            pops++;
            hold = rand_gap ? $urandom_range(0, 2) : gap_len;
        end else if (hold > 0) begin
            hold--;
        end
        bus.buffer_empty      = (fifo.size() == 0) || (hold > 0);
        bus.buffer_data       = bus.buffer_empty ? $urandom() : fifo[0];
        bus.controller_active = rand_ca ? ($urandom_range(0, 3) == 0) : ca_next;
        #1;
        cyc++;
        n_en = $countones({bus.inst_write_enable, bus.w_write_enable, bus.xy_write_enable});
        check("one_hot_enable", n_en <= 1);
        check("pop_while_empty", (bus.buffer_read_enable & bus.buffer_empty) === 1'b0);
        if (n_en != 0) begin
            obs.data = bus.write_data;
            obs.nu   = 2'b00;
            if (bus.inst_write_enable) begin
                obs.mem  = 2'd0;
                obs.addr = bus.inst_write_addr;
            end else if (bus.xy_write_enable) begin
                obs.mem  = 2'd2;
                obs.addr = bus.xy_write_addr;
            end else begin
                obs.mem  = 2'd1;
                obs.addr = bus.w_write_addr;
                for (int i = 0; i < 4; i++) if (bus.w_write_enable[i]) obs.nu = 2'(i);
            end
            write_cycles.push_back(cyc);
            have_exp = (exp_q.size() != 0);
            check("write_expected", have_exp === 1'b1);
            if (have_exp) begin
                e = exp_q.pop_front();
                check("write_record", obs === e);
            end
        end
        if (bus.controller_start) start_seen++;
        if (bus.buffer_read_enable) pop_cycles.push_back(cyc);
        pop_flag = bus.buffer_read_enable;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((fifo.size() != 0 || exp_q.size() != 0 || bus.busy || pop_flag) && n < 400) begin
            cycle();
            n++;
        end
        cycle();
        cycle();
        check("idle_within_budget", n < 400);
        check("expected_writes_done", exp_q.size() == 0);
    endtask

    task automatic push_pkt(input logic [1:0] tgt, input logic [5:0] nu, input int len, input int base);
        logic [31:0] w;
        bit          illegal;
        fifo.push_back({tgt, nu, 12'(len), 12'(base)});
        if (tgt == 2'b11) begin
            exp_starts++;
            return;
        end
        illegal = ((tgt == 2'b01) && (nu >= 6'd4)) || (base + len > 256);
        if (len != 0 && illegal) exp_error = 1'b1;
        for (int i = 0; i < len; i++) begin
            w = $urandom();
            fifo.push_back(w);
            if (!illegal)
                exp_q.push_back('{mem: tgt, nu: (tgt == 2'b01) ? nu[1:0] : 2'b00,
                                  addr: 8'(base + i), data: w});
        end
    endtask

    task automatic check_all_zero();
        check("rst_read_enable", bus.buffer_read_enable === 1'b0);
        check("rst_start", bus.controller_start === 1'b0);
        check("rst_inst_we", bus.inst_write_enable === 1'b0);
        check("rst_w_we", bus.w_write_enable === 4'b0000);
        check("rst_xy_we", bus.xy_write_enable === 1'b0);
        check("rst_inst_addr", bus.inst_write_addr === 8'h00);
        check("rst_w_addr", bus.w_write_addr === 8'h00);
        check("rst_xy_addr", bus.xy_write_addr === 8'h00);
        check("rst_write_data", bus.write_data === 32'h0);
        check("rst_busy", bus.busy === 1'b0);
        check("rst_error", bus.error === 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int p0;
        int sel;
        int len;
        int base;
        logic [1:0]  t;
        logic [5:0]  nu;
        logic [31:0] w;

        reset = 1'b0;
        bus.buffer_empty      = 1'b1;
        bus.buffer_data       = 32'h0;
        bus.controller_active = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero();
        reset = 1'b1;

        pop_cycles.delete();
        write_cycles.delete();
        push_pkt(2'b00, 6'd0, 3, 'h10);
        wait_idle();
        check("inst_write_count", write_cycles.size() == 3);
        check("inst_first_latency", (write_cycles[0] - pop_cycles[0]) == 2);
        check("inst_consecutive", (write_cycles[2] - write_cycles[0]) == 2);
        check("inst_busy_low", bus.busy === 1'b0);

        pop_cycles.delete();
        write_cycles.delete();
        gap_len = 2;
        push_pkt(2'b01, 6'd2, 2, 5);
        wait_idle();
        gap_len = 0;
        check("w_write_count", write_cycles.size() == 2);
        check("w_write_gap", (write_cycles[1] - write_cycles[0]) == 3);

        pop_cycles.delete();
        write_cycles.delete();
        ca_next = 1'b1;
        push_pkt(2'b00, 6'd0, 2, 'h20);
        repeat (10) begin
            cycle();
            check("stall_no_pop", bus.buffer_read_enable === 1'b0);
        end
        ca_next = 1'b0;
        cycle();
        check("pop_on_release", bus.buffer_read_enable === 1'b1);
        wait_idle();
        check("interlock_write_count", write_cycles.size() == 2);

        write_cycles.delete();
        p0 = pops;
        push_pkt(2'b01, 6'd7, 4, 0);
        wait_idle();
        check("bad_nu_error", bus.error === 1'b1);
        check("bad_nu_pops", (pops - p0) == 5);
        check("bad_nu_no_writes", write_cycles.size() == 0);
        push_pkt(2'b10, 6'd0, 3, 'h40);
        wait_idle();
        check("xy_after_error_count", write_cycles.size() == 3);

        write_cycles.delete();
        p0 = pops;
        push_pkt(2'b00, 6'd0, 3, 'hFE);
        wait_idle();
        check("bad_range_pops", (pops - p0) == 4);
        check("bad_range_no_writes", write_cycles.size() == 0);
        check("bad_range_error", bus.error === 1'b1);

        pop_cycles.delete();
        write_cycles.delete();
        start_seen = 0;
        exp_starts = 0;
        push_pkt(2'b11, 6'd0, 0, 0);
        push_pkt(2'b10, 6'd0, 1, 0);
        push_pkt(2'b10, 6'd0, 1, 1);
        wait_idle();
        check("ctrl_start_cycles", start_seen == 1);
        check("b2b_write_count", write_cycles.size() == 2);
        check("b2b_write_spacing", (write_cycles[1] - write_cycles[0]) == 2);
        check("b2b_pop_count", pop_cycles.size() == 5);
        check("b2b_pops_contiguous", (pop_cycles[4] - pop_cycles[0]) == 4);

        rand_gap = 1'b1;
        rand_ca  = 1'b1;
        for (int k = 0; k < 30; k++) begin
            sel  = $urandom_range(0, 9);
            len  = $urandom_range(1, 8);
            t    = 2'($urandom_range(0, 2));
            nu   = (t == 2'b01) ? 6'($urandom_range(0, 3)) : 6'($urandom_range(0, 63));
            base = $urandom_range(0, 256 - len);
            if (sel == 0) base = $urandom_range(257 - len, 4095);
            else if (sel == 1 && t == 2'b01) nu = 6'($urandom_range(4, 63));
            else if (sel == 2) t = 2'b11;
            push_pkt(t, nu, len, base);
        end
        wait_idle();
        rand_gap = 1'b0;
        rand_ca  = 1'b0;
        check("random_starts", start_seen == exp_starts);
        check("random_error", bus.error === exp_error);

        write_cycles.delete();
        fifo.push_back(32'h00003030);
        for (int i = 0; i < 3; i++) begin
            w = $urandom();
            fifo.push_back(w);
            if (i == 0) exp_q.push_back('{mem: 2'd0, nu: 2'd0, addr: 8'h30, data: w});
        end
        n = 0;
        while (write_cycles.size() == 0 && n < 40) begin
            cycle();
            n++;
        end
        check("midreset_first_write", write_cycles.size() == 1);
        #1;
        reset = 1'b0;
        #1;
        check_all_zero();
        pop_flag = 1'b0;
        fifo.delete();
        bus.buffer_empty = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        exp_error = 1'b0;
        check("midreset_error_cleared", bus.error === 1'b0);
        write_cycles.delete();
        push_pkt(2'b10, 6'd0, 2, 'h80);
        wait_idle();
        check("post_reset_write_count", write_cycles.size() == 2);
        check("post_reset_error", bus.error === 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
